cond_unit: RTL and testbench
============================

// Module: cond_unit
// PURPOSE
//  Registered conditional-execution unit: holds NZCV flags for NUM_CTX contexts, evaluates the
//  4-bit ARM condition field against the selected context's flags, and gates PCSrc/RegWrite/
//  MemWrite. Flag groups are written only by instructions whose condition passes. Saturating
//  executed/squashed counters are included. Sits between decoder/ALU and the writeback/PC logic.
// PARAMETERS
//  NUM_CTX   2   number of independent NZCV flag sets (>=1)
//  CNT_W     16  width of the executed/squashed counters
//  NV_NEVER  1   cond 4'b1111: 1 -> never executes, 0 -> always executes
//  REG_OUT   1   1 -> control outputs registered (latency 1), 0 -> combinational (latency 0)
// PORTS
//  clk          in   1             clock, all state on rising edge
//  rst_n        in   1             asynchronous active-low reset
//  valid_i      in   1             instruction present this cycle
//  cond_i       in   4             condition field Instr[31:28]
//  ctx_i        in   CTX_W         flag context select, CTX_W = max(1,$clog2(NUM_CTX))
//  alu_flags_i  in   4             ALU result flags {N,Z,C,V}
//  flag_w_i     in   2             [1]: write N,Z  [0]: write C,V
//  pcs_i        in   1             decoder PCSrc request
//  reg_w_i      in   1             decoder RegWrite request
//  mem_w_i      in   1             decoder MemWrite request
//  cnt_clr_i    in   1             synchronous clear of both counters
//  valid_o      out  1             valid_i aligned to control outputs
//  cond_ex_o    out  1             condition passed (0 when not valid)
//  pc_src_o     out  1             pcs_i & pass
//  reg_write_o  out  1             reg_w_i & pass
//  mem_write_o  out  1             mem_w_i & pass
//  flags_o      out  4             stored flags of context ctx_i (combinational read)
//  exec_cnt_o   out  CNT_W         valid instructions that passed
//  squash_cnt_o out  CNT_W         valid instructions that failed
// BEHAVIOUR
//  - Reset (rst_n=0, async): all flag sets 4'b0000, counters 0, all registered outputs 0.
//  - pass = valid_i & ctx_ok & eval(cond_i, flags[ctx_i]); ctx_ok = (ctx_i < NUM_CTX).
//  - eval: 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V; 8 HI C&~Z;
//    9 LS ~C|Z; A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE Z|(N!=V); E AL 1; F ~NV_NEVER.
//    No X output for any cond value.
//  - Flag update at clock edge when pass: flag_w_i[1] -> {N,Z} <= alu_flags_i[3:2];
//    flag_w_i[0] -> {C,V} <= alu_flags_i[1:0]. Groups independent. Other contexts untouched.
//  - Evaluation uses pre-edge flags; an instruction cannot see its own flag write. The next
//    cycle's instruction on the same context sees the new flags (no extra bypass).
//  - REG_OUT=1: valid_o/cond_ex_o/pc_src_o/reg_write_o/mem_write_o registered, 1-cycle latency.
//    REG_OUT=0: same equations combinational. flags_o is always combinational.
//  - Counters: exec +1 on pass, squash +1 on valid_i & ~pass (incl. ctx_ok=0); both saturate at
//    all-ones. cnt_clr_i wins over a same-cycle increment (result 0).
//  - ctx_i out of range: treated as failed condition, no flag write, squash counted.
//  - Reset asserted mid-operation clears everything immediately; first instruction after release
//    evaluates against zero flags (EQ fails, NE passes).
// STRUCTURE
//  - cond_pkg: cond_e enum (EQ..NV), flag index localparams N_IDX=3,Z_IDX=2,C_IDX=1,V_IDX=0,
//    function cond_eval(cond, flags, nv_never).
//  - Sub-module cond_eval_comb: pure combinational evaluator wrapping the function; cond_unit
//    holds flag array, gating, output pipeline and counters.
// TESTING
//  1 reset, ctx0, valid, cond=0 EQ, flag_w=11, alu=0100 -> cond_ex=0, flags unchanged 0000,
//    squash=1; cond=1 NE, alu=0100, flag_w=11 -> pass, flags_o next cycle 0100, exec=1.
//  2 Sweep all 16 conds x 16 flag values on ctx0 vs golden model, both NV_NEVER settings.
//  3 flags=0000, flag_w=10, alu=1111, cond=E -> flags 1100; then flag_w=01, alu=0011 -> 1111.
//  4 Context isolation: write ctx1=0100, ctx0 stays 0000; ctx_i=2 with NUM_CTX=3 uses ctx2,
//    NUM_CTX=2 & ctx_i=3 -> fail, no write, squash+1.
//  5 REG_OUT=1: pcs/reg_w/mem_w=1, cond pass at cycle t -> outputs high at t+1 only; fail -> 0.
//  6 CNT_W=4: 20 passes -> exec_cnt=15 held; cnt_clr with pass same cycle -> 0; rst_n pulse
//    mid-stream -> flags/counters/outputs 0 asynchronously.

Source files
------------

// File: rtl/cond_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// cond_pkg: condition codes, NZCV bit positions, condition evaluator
// Rev 1.0
// ------------------------------------------------------------------
package cond_pkg;

   typedef enum logic [3:0] {
      EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
      MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
      HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
      GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
   } cond_e;

   localparam int N_IDX = 3;
   localparam int Z_IDX = 2;
   localparam int C_IDX = 1;
   localparam int V_IDX = 0;

   function automatic logic cond_eval(input logic [3:0] cond,
                                      input logic [3:0] flags,
                                      input logic       nv_never);
      logic n, z, c, v, r;
      n = flags[N_IDX];
      z = flags[Z_IDX];
      c = flags[C_IDX];
      v = flags[V_IDX];
      r = 1'b0;
      case (cond_e'(cond))
         EQ: r = z;
         NE: r = ~z;
         CS: r = c;
         CC: r = ~c;
         MI: r = n;
         PL: r = ~n;
         VS: r = v;
         VC: r = ~v;
         HI: r = c & ~z;
         LS: r = ~c | z;
         GE: r = (n == v);
         LT: r = (n != v);
         GT: r = ~z & (n == v);
         LE: r = z | (n != v);
         AL: r = 1'b1;
         NV: r = ~nv_never;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cond_eval_comb.sv
`default_nettype none
// ------------------------------------------------------------------
// cond_eval_comb: combinational condition-field evaluator
// Rev 1.0
// ------------------------------------------------------------------
module cond_eval_comb
   import cond_pkg::*;
#(
   parameter bit NV_NEVER = 1'b1
) (
   input  logic [3:0] cond_i,
   input  logic [3:0] flags_i,
   output logic       pass_o
);

   assign pass_o = cond_eval(cond_i, flags_i, NV_NEVER);

endmodule
`default_nettype wire

// File: rtl/cond_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// cond_unit: conditional-execution unit with per-context NZCV flags
// Rev 1.0
// ------------------------------------------------------------------
module cond_unit
   import cond_pkg::*;
#(
   parameter int NUM_CTX  = 2,
   parameter int CNT_W    = 16,
   parameter bit NV_NEVER = 1'b1,
   parameter bit REG_OUT  = 1'b1,
   parameter int CTX_W    = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_i,
   input  logic [3:0]       cond_i,
   input  logic [CTX_W-1:0] ctx_i,
   input  logic [3:0]       alu_flags_i,
   input  logic [1:0]       flag_w_i,
   input  logic             pcs_i,
   input  logic             reg_w_i,
   input  logic             mem_w_i,
   input  logic             cnt_clr_i,
   output logic             valid_o,
   output logic             cond_ex_o,
   output logic             pc_src_o,
   output logic             reg_write_o,
   output logic             mem_write_o,
   output logic [3:0]       flags_o,
   output logic [CNT_W-1:0] exec_cnt_o,
   output logic [CNT_W-1:0] squash_cnt_o
);

   logic [3:0]       r_flags [NUM_CTX];
   logic [3:0]       w_sel_flags;
   logic             w_ctx_ok;
   logic             w_cond_true;
   logic             w_pass;
   logic [CNT_W-1:0] r_exec;
   logic [CNT_W-1:0] r_squash;

   // Loop-based select keeps out-of-range contexts well defined for any NUM_CTX.
   always_comb begin
      w_sel_flags = 4'b0000;
      w_ctx_ok    = 1'b0;
      for (int k = 0; k < NUM_CTX; k++) begin
         if (ctx_i == CTX_W'(k)) begin
            w_sel_flags = r_flags[k];
            w_ctx_ok    = 1'b1;
         end
      end
   end

   cond_eval_comb #(
      .NV_NEVER (NV_NEVER)
   ) u_eval (
      .cond_i  (cond_i),
      .flags_i (w_sel_flags),
      .pass_o  (w_cond_true)
   );

   assign w_pass  = valid_i & w_ctx_ok & w_cond_true;
   assign flags_o = w_sel_flags;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_CTX; k++) r_flags[k] <= 4'b0000;
      end else if (w_pass) begin
         for (int k = 0; k < NUM_CTX; k++) begin
            if (ctx_i == CTX_W'(k)) begin
               if (flag_w_i[1]) begin
                  r_flags[k][N_IDX] <= alu_flags_i[N_IDX];
                  r_flags[k][Z_IDX] <= alu_flags_i[Z_IDX];
               end
               if (flag_w_i[0]) begin
                  r_flags[k][C_IDX] <= alu_flags_i[C_IDX];
                  r_flags[k][V_IDX] <= alu_flags_i[V_IDX];
               end
            end
         end
      end
   end

   generate
      if (REG_OUT) begin : g_reg_out
         logic r_valid, r_cond_ex, r_pc_src, r_reg_write, r_mem_write;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_valid     <= 1'b0;
               r_cond_ex   <= 1'b0;
               r_pc_src    <= 1'b0;
               r_reg_write <= 1'b0;
               r_mem_write <= 1'b0;
            end else begin
               r_valid     <= valid_i;
               r_cond_ex   <= w_pass;
               r_pc_src    <= pcs_i & w_pass;
               r_reg_write <= reg_w_i & w_pass;
               r_mem_write <= mem_w_i & w_pass;
            end
         end
         assign valid_o     = r_valid;
         assign cond_ex_o   = r_cond_ex;
         assign pc_src_o    = r_pc_src;
         assign reg_write_o = r_reg_write;
         assign mem_write_o = r_mem_write;
      end else begin : g_comb_out
         assign valid_o     = valid_i;
         assign cond_ex_o   = w_pass;
         assign pc_src_o    = pcs_i & w_pass;
         assign reg_write_o = reg_w_i & w_pass;
         assign mem_write_o = mem_w_i & w_pass;
      end
   endgenerate

   // Clear takes priority over any same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_exec   <= '0;
         r_squash <= '0;
      end else if (cnt_clr_i) begin
         r_exec   <= '0;
         r_squash <= '0;
      end else if (valid_i) begin
         if (w_pass) begin
            if (r_exec != '1) r_exec <= r_exec + CNT_W'(1);
         end else begin
            if (r_squash != '1) r_squash <= r_squash + CNT_W'(1);
         end
      end
   end

   assign exec_cnt_o   = r_exec;
   assign squash_cnt_o = r_squash;

endmodule
`default_nettype wire

// File: tb/tb_cond_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_cond_unit: two configurations of cond_unit against a scoreboard model
// Rev 1.0
// ------------------------------------------------------------------
module tb_cond_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, valid, pcs, rw, mw, clr;
   logic [3:0] cond, alu;
   logic [1:0] ctx, fw;

   // A: NUM_CTX=2, CNT_W=16, NV_NEVER=1, REG_OUT=1
   logic        a_valid, a_cex, a_pcs, a_rw, a_mw;
   logic [3:0]  a_flags;
   logic [15:0] a_exec, a_squash;
   // B: NUM_CTX=3, CNT_W=4, NV_NEVER=0, REG_OUT=0
   logic        b_valid, b_cex, b_pcs, b_rw, b_mw;
   logic [3:0]  b_flags;
   logic [3:0]  b_exec, b_squash;

   cond_unit #(.NUM_CTX(2), .CNT_W(16), .NV_NEVER(1'b1), .REG_OUT(1'b1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .valid_i(valid), .cond_i(cond), .ctx_i(ctx[0]),
      .alu_flags_i(alu), .flag_w_i(fw), .pcs_i(pcs), .reg_w_i(rw), .mem_w_i(mw),
      .cnt_clr_i(clr), .valid_o(a_valid), .cond_ex_o(a_cex), .pc_src_o(a_pcs),
      .reg_write_o(a_rw), .mem_write_o(a_mw), .flags_o(a_flags),
      .exec_cnt_o(a_exec), .squash_cnt_o(a_squash));

   cond_unit #(.NUM_CTX(3), .CNT_W(4), .NV_NEVER(1'b0), .REG_OUT(1'b0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .valid_i(valid), .cond_i(cond), .ctx_i(ctx),
      .alu_flags_i(alu), .flag_w_i(fw), .pcs_i(pcs), .reg_w_i(rw), .mem_w_i(mw),
      .cnt_clr_i(clr), .valid_o(b_valid), .cond_ex_o(b_cex), .pc_src_o(b_pcs),
      .reg_write_o(b_rw), .mem_write_o(b_mw), .flags_o(b_flags),
      .exec_cnt_o(b_exec), .squash_cnt_o(b_squash));

   int n_total = 0;
   int n_bad   = 0;

   logic [4:0] q_a [$];
   logic [3:0] m_fa [2];
   logic [3:0] m_fb [3];
   int m_ea, m_sa, m_eb, m_sb;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ARM-style: cond[3:1] picks a base test, cond[0] inverts it.
   function automatic logic golden(input logic [3:0] c, input logic [3:0] f, input logic nv);
      logic n, z, cf, v, base;
      {n, z, cf, v} = f;
      if (c[3:1] == 3'b111) return c[0] ? ~nv : 1'b1;
      case (c[3:1])
         3'd0:    base = z;
         3'd1:    base = cf;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = cf & ~z;
         3'd5:    base = (n == v);
         default: base = ~z & (n == v);
      endcase
      return base ^ c[0];
   endfunction

   task automatic model_reset();
      q_a.delete();
      m_fa[0] = 4'h0; m_fa[1] = 4'h0;
      m_fb[0] = 4'h0; m_fb[1] = 4'h0; m_fb[2] = 4'h0;
      m_ea = 0; m_sa = 0; m_eb = 0; m_sb = 0;
   endtask

   task automatic upd_flags(inout logic [3:0] f, input logic [3:0] a, input logic [1:0] w);
      if (w[1]) f[3:2] = a[3:2];
      if (w[0]) f[1:0] = a[1:0];
   endtask

   task automatic step(input logic v, input logic [3:0] c, input logic [1:0] cx,
                       input logic [3:0] a, input logic [1:0] w, input logic [2:0] ctl,
                       input logic cl);
      logic pa, pb;
      logic [4:0] ea, eb;
      @(negedge clk);
      valid = v; cond = c; ctx = cx; alu = a; fw = w; {pcs, rw, mw} = ctl; clr = cl;
      #1;
      pa = v && golden(c, m_fa[cx[0]], 1'b1);
      pb = v && ((cx < 2'd3) ? golden(c, m_fb[cx], 1'b0) : 1'b0);
      eb = {v, pb, ctl[2] & pb, ctl[1] & pb, ctl[0] & pb};
      ea = {v, pa, ctl[2] & pa, ctl[1] & pa, ctl[0] & pa};
      chk("b_ctl", {b_valid, b_cex, b_pcs, b_rw, b_mw}, eb);
      chk("a_flags", a_flags, m_fa[cx[0]]);
      if (cx < 2'd3) chk("b_flags", b_flags, m_fb[cx]);
      q_a.push_back(ea);
      if (pa) upd_flags(m_fa[cx[0]], a, w);
      if (pb) upd_flags(m_fb[cx], a, w);
      if (cl) begin
         m_ea = 0; m_sa = 0; m_eb = 0; m_sb = 0;
      end else if (v) begin
         if (pa) m_ea = (m_ea == 65535) ? m_ea : m_ea + 1;
         else    m_sa = (m_sa == 65535) ? m_sa : m_sa + 1;
         if (pb) m_eb = (m_eb == 15) ? m_eb : m_eb + 1;
         else    m_sb = (m_sb == 15) ? m_sb : m_sb + 1;
      end
      @(posedge clk);
      #1;
      ea = (q_a.size() > 0) ? q_a.pop_front() : 5'bxxxxx;
      chk("a_ctl", {a_valid, a_cex, a_pcs, a_rw, a_mw}, ea);
      chk("a_exec", a_exec, m_ea);
      chk("a_squash", a_squash, m_sa);
      chk("b_exec", b_exec, m_eb);
      chk("b_squash", b_squash, m_sb);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_a_ctl"}, {a_valid, a_cex, a_pcs, a_rw, a_mw}, 5'b0);
      chk({tag, "_a_flags"}, a_flags, 4'h0);
      chk({tag, "_a_cnt"}, {a_exec, a_squash}, 32'h0);
      chk({tag, "_b_flags"}, b_flags, 4'h0);
      chk({tag, "_b_cnt"}, {b_exec, b_squash}, 8'h0);
   endtask

   task automatic mid_reset();
      @(negedge clk);
      valid = 1'b0; clr = 1'b0; ctx = 2'd0;
      #2 rst_n = 1'b0;
      #1 check_all_zero("mid_rst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; valid = 1'b0; cond = 4'h0; ctx = 2'd0; alu = 4'h0; fw = 2'b00;
      pcs = 1'b0; rw = 1'b0; mw = 1'b0; clr = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 check_all_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // EQ fails on zero flags, NE passes and writes
      step(1'b1, 4'h0, 2'd0, 4'b0100, 2'b11, 3'b111, 1'b0);
      chk("t1_squash", a_squash, 32'd1);
      chk("t1_flags0", a_flags, 4'b0000);
      step(1'b1, 4'h1, 2'd0, 4'b0100, 2'b11, 3'b111, 1'b0);
      chk("t1_flags1", a_flags, 4'b0100);
      chk("t1_exec", a_exec, 32'd1);

      // independent flag groups
      step(1'b1, 4'hE, 2'd0, 4'b0000, 2'b11, 3'b000, 1'b0);
      step(1'b1, 4'hE, 2'd0, 4'b1111, 2'b10, 3'b000, 1'b0);
      chk("t3_nz", a_flags, 4'b1100);
      step(1'b1, 4'hE, 2'd0, 4'b0011, 2'b01, 3'b000, 1'b0);
      chk("t3_cv", a_flags, 4'b1111);

      // context isolation and out-of-range context
      step(1'b1, 4'hE, 2'd1, 4'b0100, 2'b11, 3'b000, 1'b0);
      chk("t4_ctx1", a_flags, 4'b0100);
      step(1'b0, 4'h0, 2'd0, 4'b0000, 2'b00, 3'b000, 1'b0);
      chk("t4_ctx0", a_flags, 4'b1111);
      step(1'b1, 4'hE, 2'd2, 4'b1010, 2'b11, 3'b000, 1'b0);
      step(1'b0, 4'h0, 2'd2, 4'b0000, 2'b00, 3'b000, 1'b0);
      chk("t4_ctx2", b_flags, 4'b1010);
      step(1'b1, 4'hE, 2'd3, 4'b0101, 2'b11, 3'b111, 1'b0);
      step(1'b0, 4'h0, 2'd3, 4'b0000, 2'b00, 3'b000, 1'b0);

      // random traffic including gating, idle cycles and clears
      for (int i = 0; i < 60; i++)
         step(1'($urandom_range(0, 3) != 0), 4'($urandom), 2'($urandom), 4'($urandom),
              2'($urandom), 3'($urandom), 1'($urandom_range(0, 15) == 0));

      // full cond x flags sweep on ctx0
      for (int c = 0; c < 16; c++) begin
         for (int f = 0; f < 16; f++) begin
            step(1'b1, 4'hE, 2'd0, 4'(f), 2'b11, 3'b000, 1'b0);
            step(1'b1, 4'(c), 2'd0, 4'($urandom), 2'($urandom), 3'($urandom), 1'b0);
         end
      end

      mid_reset();
      step(1'b1, 4'h0, 2'd0, 4'b0000, 2'b00, 3'b111, 1'b0);
      step(1'b1, 4'h1, 2'd0, 4'b0000, 2'b00, 3'b111, 1'b0);

      // saturation of the narrow counter, then clear racing a pass
      mid_reset();
      for (int i = 0; i < 20; i++) step(1'b1, 4'hE, 2'd0, 4'h0, 2'b00, 3'b101, 1'b0);
      chk("t6_sat", b_exec, 32'd15);
      chk("t6_exec_a", a_exec, 32'd20);
      step(1'b1, 4'hE, 2'd0, 4'h0, 2'b00, 3'b101, 1'b1);
      chk("t6_clr_a", a_exec, 32'd0);
      chk("t6_clr_b", b_exec, 32'd0);
      step(1'b1, 4'hE, 2'd1, 4'h0, 2'b00, 3'b010, 1'b0);
      mid_reset();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
